// File: rtl/bias_argmax_pkg.sv
// Shared constants, state encoding and helpers for the output-layer bias/argmax block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bias_argmax_pkg;

  localparam int N_CLASSES  = 10;
  localparam int ACC_W      = 32;
  localparam int BIAS_W     = 16;
  localparam int BIAS_SHIFT = 8;
  localparam int IDX_W      = 4;

  // Saturation bounds of the signed accumulator/logit range.
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Index of the final neuron; a handshake here closes the run.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sign-extend the ROM bias to accumulator width and move its binary point
  // onto the accumulator's. BIAS_W + BIAS_SHIFT fits in ACC_W, so no bits drop.
  function automatic logic signed [ACC_W-1:0] align_bias(input logic signed [BIAS_W-1:0] b);
    logic [ACC_W-1:0] ext;
    ext = {{(ACC_W-BIAS_W){b[BIAS_W-1]}}, b};
    return $signed(ext << BIAS_SHIFT);
  endfunction

endpackage

// File: rtl/bias_argmax_if.sv
// Stream, bias-ROM and result signals of the output-layer bias/argmax block.
// Latency: n/a (wiring only).
// Backpressure: acc_valid/acc_ready handshake; logit and done are unthrottled pulses.
interface bias_argmax_if;
  import bias_argmax_pkg::*;

  logic                    start;
  logic                    acc_valid;
  logic signed [ACC_W-1:0] acc_data;
  logic                    acc_ready;
  logic [IDX_W-1:0]        bias_addr;
  logic signed [BIAS_W-1:0] bias_data;
  logic                    logit_valid;
  logic [IDX_W-1:0]        logit_idx;
  logic signed [ACC_W-1:0] logit_data;
  logic                    busy;
  logic                    done;
  logic [IDX_W-1:0]        class_out;
  logic signed [ACC_W-1:0] class_max;

  // Upstream / ROM / result consumer side.
  modport master (
    output start, acc_valid, acc_data, bias_data,
    input  acc_ready, bias_addr, logit_valid, logit_idx, logit_data,
           busy, done, class_out, class_max
  );

  // The bias/argmax block itself.
  modport slave (
    input  start, acc_valid, acc_data, bias_data,
    output acc_ready, bias_addr, logit_valid, logit_idx, logit_data,
           busy, done, class_out, class_max
  );

endinterface

// File: rtl/bias_argmax_sat_add.sv
// Combinational signed add of two W-bit operands, saturated to the W-bit signed range.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
module bias_argmax_sat_add #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  logic [W:0] sum;

  // One guard bit catches overflow: the top two bits disagree only when the
  // true result lies outside the W-bit range, and the guard bit gives its sign.
  always_comb begin
    sum = {a[W-1], a} + {b[W-1], b};
    if (sum[W] != sum[W-1]) begin
      y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      y = $signed(sum[W-1:0]);
    end
  end

endmodule

// File: rtl/bias_argmax.sv
// Adds aligned ROM bias to each of N_CLASSES streamed sums, emits saturated logits, reports argmax.
// Latency: logit 1 cycle after its handshake; done/class_* with the last logit.
// Backpressure: acc_ready high throughout RUN; a missing acc_valid stalls the run indefinitely.
module bias_argmax
  import bias_argmax_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  bias_argmax_if.slave   bus
);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] run_max;
  logic [IDX_W-1:0]        run_cls;

  logic                    hs;
  logic signed [ACC_W-1:0] bias_al;
  logic signed [ACC_W-1:0] sum;
  logic                    better;

  // The ROM read is combinational, so the address must follow idx in the
  // same cycle the sum is presented.
  assign bus.acc_ready = (state == RUN);
  assign bus.bias_addr = (state == RUN) ? idx : '0;
  assign hs            = bus.acc_valid & bus.acc_ready;
  assign bias_al       = align_bias(bus.bias_data);

  bias_argmax_sat_add #(.W(ACC_W)) u_sat_add (
    .a (bus.acc_data),
    .b (bias_al),
    .y (sum)
  );

  // Strict compare: on a tie the earlier (lower) index keeps the win.
  assign better = (sum > run_max);

  // Control FSM with registered stream and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      run_max         <= '0;
      run_cls         <= '0;
      bus.logit_valid <= 1'b0;
      bus.logit_idx   <= '0;
      bus.logit_data  <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.class_out   <= '0;
      bus.class_max   <= '0;
    end else begin
      bus.logit_valid <= 1'b0;
      bus.done        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            idx      <= '0;
            run_max  <= ACC_MIN;
            run_cls  <= '0;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          if (hs) begin
            bus.logit_valid <= 1'b1;
            bus.logit_idx   <= idx;
            bus.logit_data  <= sum;
            if (better) begin
              run_max <= sum;
              run_cls <= idx;
            end
            if (idx == LAST_IDX) begin
              // Publish the final winner directly, folding in this last logit.
              state         <= DONE;
              idx           <= '0;
              bus.done      <= 1'b1;
              bus.class_out <= better ? idx : run_cls;
              bus.class_max <= better ? sum : run_max;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DONE: begin
          // start here is deliberately dropped: the block is not IDLE yet.
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bias_argmax.md
Name: bias_argmax

Overview:
- Output-layer post-processing for the MNIST classifier, directly downstream of the 10-entry bias ROM.
- Accepts the 10 raw output-neuron dot-product sums as a stream, one per handshake.
- For each sum: drives the bias ROM address, adds the fixed-point-aligned bias, saturates, and emits the logit.
- Tracks the running maximum and reports the winning digit once all 10 sums have been accepted.

Parameters:
- N_CLASSES, 10, number of output neurons / digits; must fit in 4-bit index.
- ACC_W, 32, width of signed accumulator sums and logits.
- BIAS_W, 16, width of signed bias word from ROM.
- BIAS_SHIFT, 8, left shift applied to bias to align its binary point with the accumulator's.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a classification; ignored unless IDLE
- acc_valid  in  1  acc_data carries the sum for the current neuron index
- acc_data  in  ACC_W  signed dot-product sum, neurons presented in order 0..N_CLASSES-1
- acc_ready  out  1  block accepts acc_data this cycle
- bias_addr  out  4  address to bias ROM, equals current neuron index
- bias_data  in  BIAS_W  signed bias from ROM, combinational read of bias_addr
- logit_valid  out  1  one-cycle pulse, logit_data/logit_idx valid
- logit_idx  out  4  neuron index of logit_data
- logit_data  out  ACC_W  signed saturated acc_data + (bias_data <<< BIAS_SHIFT)
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, class_out/class_max final
- class_out  out  4  index of maximum logit; held until next start
- class_max  out  ACC_W  value of maximum logit; held until next start

Behaviour:
- Reset values: state=IDLE, idx=0, acc_ready=0, bias_addr=0, logit_valid=0, logit_idx=0, logit_data=0, busy=0, done=0, class_out=0, class_max=0.
  - Reset is asynchronous and may assert mid-run; the run is abandoned with no done pulse.
- FSM IDLE:
  - acc_ready=0, bias_addr=0.
  - start -> RUN; idx<=0; running max <= most-negative ACC_W value; running class <= 0.
- FSM RUN:
  - acc_ready=1 (combinational from state); bias_addr=idx (combinational).
  - Handshake = acc_valid & acc_ready. Without a handshake, nothing changes; the block stalls indefinitely.
  - On handshake, the bias is sampled in the same cycle (ROM is combinational).
  - sum = sign-extended acc_data + sign-extended (bias_data <<< BIAS_SHIFT), computed in ACC_W+1 bits, then saturated to the ACC_W signed range (max 0x7FFFFFFF, min 0x80000000 at default).
  - Registered outputs, 1 cycle latency: logit_valid=1, logit_idx=idx, logit_data=sum.
  - Max update: if sum > running max (strict signed compare), max<=sum and class<=idx. Ties keep the lower index.
  - idx increments on handshake. Handshake at idx==N_CLASSES-1 -> DONE.
- FSM DONE (one cycle):
  - done=1; class_out/class_max take the final max (including the last logit).
  - done coincides with the last logit_valid. Then -> IDLE.
- start during RUN/DONE is ignored.
- start in the same cycle done is high is ignored; the block is not yet IDLE.
- acc_valid in IDLE is ignored (acc_ready=0).
- class_out/class_max change only at done; they are unchanged during a run and after reset stay 0.

Decomposition:
- Shared package holds:
  - constants N_CLASSES=10, ACC_W, BIAS_W, BIAS_SHIFT, IDX_W=4;
  - state encoding IDLE/RUN/DONE;
  - saturation bounds ACC_MAX/ACC_MIN.
- One natural sub-module: sat_add, a combinational signed add with saturation to ACC_W, reusable by hidden-layer neurons.
- The bias ROM is instantiated at top level, not inside this block.

Test Plan:
- Nominal: biases all 0x0001, acc_data = {0,100,200,...,900}·256 with no stalls -> logits = acc+256; done one cycle after the 10th handshake; class_out=9, class_max=900·256+256.
- Tie and negatives: all acc_data=-1000, biases 0 -> class_out=0, class_max=-1000; insert acc_valid gaps of 0-3 cycles -> identical logits and result, logit_idx sequence 0..9.
- Saturation: acc_data=0x7FFFFF00, bias=0x7FFF -> logit_data=0x7FFFFFFF; acc_data=0x80000010, bias=0x8000 -> logit_data=0x80000000.
- Bias alignment: bias=0xFFFF (-1), acc=0 -> logit=-256; bias_addr equals current idx in every RUN cycle.
- Protocol: start pulsed during RUN and in the done cycle -> no restart, idx continues; acc_valid in IDLE -> no logit_valid; back-to-back runs -> second result replaces first only at its done.
- Reset mid-run: assert rst after 5 handshakes -> all outputs 0 immediately; no done pulse; new start after release -> clean 10-sample run.
